mmio_bridge: RTL

- Parametrised memory-mapped I/O bridge between the CPU core's load/store port and the data memory plus board I/O (switches, buttons, LEDs, 7-segment value).
- Replaces the single-cycle combinational mem/IO split with a handshaked, multi-cycle access FSM.
- Adds synchronised inputs, sticky button-event latching with write-1-to-clear, and configurable memory wait states.

---
 rtl/mmio_pkg.sv | 23 ++
 rtl/mmio_btn_event.sv | 73 +++++++
 rtl/mmio_bridge.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped I/O bridge: register offsets
// inside the I/O window, the access FSM state type and the width of the
// address field that selects the I/O window.
package mmio_pkg;

    // Upper address bits compared against the I/O base (addr[31:10])
    localparam int IO_SEL_W = 22;

    // Word-aligned register offsets inside the I/O window (addr[9:0])
    localparam logic [9:0] OFF_SW      = 10'h000;
    localparam logic [9:0] OFF_BTN_EVT = 10'h004;
    localparam logic [9:0] OFF_BTN_LVL = 10'h008;
    localparam logic [9:0] OFF_LED     = 10'h010;
    localparam logic [9:0] OFF_SEG     = 10'h020;

    // Access FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MWAIT = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/mmio_btn_event.sv
// One button channel: 2-flop synchroniser, optional debounce filter
// (MMIO_DEBOUNCE_EN), rising-edge detector and a sticky event bit that
// software clears by writing 1. A rising edge in the same cycle as a
// clear keeps the bit set so no press is ever lost.
module mmio_btn_event
    import mmio_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic clr,
    output logic evt,
    output logic lvl
);

    logic sync1_r;
    logic sync2_r;
    logic lvl_s;
    logic lvl_prev_r;
    logic evt_r;

    // Two-flop synchroniser for the asynchronous button pin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

`ifdef MMIO_DEBOUNCE_EN
    logic [19:0] db_cnt_r;
    logic        db_lvl_r;

    // Accept a new level only after it has been stable for DEBOUNCE_CYCLES samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt_r <= 20'd0;
            db_lvl_r <= 1'b0;
        end else if (sync2_r == db_lvl_r) begin
            db_cnt_r <= 20'd0;
        end else if (db_cnt_r == (DEBOUNCE_CYCLES - 20'd1)) begin
            db_cnt_r <= 20'd0;
            db_lvl_r <= sync2_r;
        end else begin
            db_cnt_r <= db_cnt_r + 20'd1;
        end
    end

    assign lvl_s = db_lvl_r;
`else
    assign lvl_s = sync2_r;
`endif

    // Edge history and sticky event: a new edge overrides a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_prev_r <= 1'b0;
            evt_r      <= 1'b0;
        end else begin
            lvl_prev_r <= lvl_s;
            evt_r      <= (lvl_s & ~lvl_prev_r) | (evt_r & ~clr);
        end
    end

    assign evt = evt_r;
    assign lvl = lvl_s;

endmodule

// File: rtl/mmio_bridge.sv
// Handshaked bridge between the CPU load/store port and data memory plus
// board I/O. Requests are held by the CPU until the one-cycle ready pulse.
// I/O accesses and memory writes finish one cycle after the request; memory
// reads take MEM_WAIT extra cycles. Define MMIO_DEBOUNCE_EN to put a
// debounce filter in each button channel.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int          NUM_SW          = 16,
    parameter int          NUM_BTN         = 3,
    parameter int          NUM_LED         = 16,
    parameter logic [31:0] IO_BASE         = 32'hFFFF_FC00,
    parameter int          MEM_WAIT        = 1,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_rd,
    input  logic               req_wr,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    output logic               mem_re,
    output logic               mem_we,
    input  logic [31:0]        mem_rdata,
    input  logic [NUM_SW-1:0]  sw_in,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_LED-1:0] led_out,
    output logic [31:0]        seg_value,
    output logic               seg_valid
);

    // Counter preload: MWAIT lasts MEM_WAIT cycles, the last one at count 0
    localparam logic [3:0] WAIT_LOAD = (MEM_WAIT == 0) ? 4'd0 : 4'(MEM_WAIT - 1);

    state_e              state_r;
    state_e              next_state_s;
    logic [3:0]          wait_cnt_r;
    logic [3:0]          wait_cnt_next_s;
    logic [31:0]         rdata_r;
    logic [31:0]         rdata_next_s;
    logic                ready_r;
    logic                mem_re_s;
    logic                mem_we_s;

    logic                io_sel_s;
    logic                is_wr_s;
    logic                is_rd_s;
    logic                io_wr_s;
    logic [31:0]         io_rdata_s;

    logic [NUM_SW-1:0]   sw_sync1_r;
    logic [NUM_SW-1:0]   sw_sync2_r;
    logic [NUM_BTN-1:0]  btn_evt_s;
    logic [NUM_BTN-1:0]  btn_lvl_s;
    logic [NUM_BTN-1:0]  btn_clr_s;
    logic [NUM_LED-1:0]  led_r;
    logic [31:0]         seg_r;
    logic                seg_valid_r;

    // Request decode: a combined read+write is handled as a write
    always_comb begin
        io_sel_s = (addr[31 -: IO_SEL_W] == IO_BASE[31 -: IO_SEL_W]);
        is_wr_s  = req_wr;
        is_rd_s  = req_rd & ~req_wr;
        io_wr_s  = (state_r == IDLE) & is_wr_s & io_sel_s;
        if (io_wr_s && (addr[9:0] == OFF_BTN_EVT)) begin
            btn_clr_s = wdata[NUM_BTN-1:0];
        end else begin
            btn_clr_s = {NUM_BTN{1'b0}};
        end
    end

    // I/O read mux; unmapped or unaligned offsets read as zero
    always_comb begin
        io_rdata_s = 32'h0;
        case (addr[9:0])
            OFF_SW:      io_rdata_s[NUM_SW-1:0]  = sw_sync2_r;
            OFF_BTN_EVT: io_rdata_s[NUM_BTN-1:0] = btn_evt_s;
            OFF_BTN_LVL: io_rdata_s[NUM_BTN-1:0] = btn_lvl_s;
            OFF_LED:     io_rdata_s[NUM_LED-1:0] = led_r;
            OFF_SEG:     io_rdata_s              = seg_r;
            default:     io_rdata_s              = 32'h0;
        endcase
    end

    // Access FSM next-state, wait counter and response data
    always_comb begin
        next_state_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        rdata_next_s    = rdata_r;
        mem_re_s        = 1'b0;
        mem_we_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (is_wr_s) begin
                    mem_we_s     = ~io_sel_s;
                    rdata_next_s = 32'h0;
                    next_state_s = RESP;
                end else if (is_rd_s && io_sel_s) begin
                    rdata_next_s = io_rdata_s;
                    next_state_s = RESP;
                end else if (is_rd_s) begin
                    mem_re_s = 1'b1;
                    if (MEM_WAIT == 0) begin
                        rdata_next_s = mem_rdata;
                        next_state_s = RESP;
                    end else begin
                        wait_cnt_next_s = WAIT_LOAD;
                        next_state_s    = MWAIT;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            MWAIT: begin
                mem_re_s = 1'b1;
                if (wait_cnt_r == 4'd0) begin
                    rdata_next_s = mem_rdata;
                    next_state_s = RESP;
                end else begin
                    wait_cnt_next_s = wait_cnt_r - 4'd1;
                end
            end
            RESP: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM state, wait counter, load data and ready pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            wait_cnt_r <= 4'd0;
            rdata_r    <= 32'h0;
            ready_r    <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= wait_cnt_next_s;
            rdata_r    <= rdata_next_s;
            ready_r    <= (next_state_s == RESP);
        end
    end

    // Memory strobes follow the FSM but are forced off while reset is held
    always_comb begin
        mem_re    = mem_re_s & ~reset;
        mem_we    = mem_we_s & ~reset;
        mem_addr  = (mem_re | mem_we) ? addr : 32'h0;
        mem_wdata = mem_we ? wdata : 32'h0;
    end

    // Switch synchroniser
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_sync1_r <= {NUM_SW{1'b0}};
            sw_sync2_r <= {NUM_SW{1'b0}};
        end else begin
            sw_sync1_r <= sw_in;
            sw_sync2_r <= sw_sync1_r;
        end
    end

    // LED and 7-segment registers, written in the request cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_r       <= {NUM_LED{1'b0}};
            seg_r       <= 32'h0;
            seg_valid_r <= 1'b0;
        end else if (io_wr_s && (addr[9:0] == OFF_LED)) begin
            led_r <= wdata[NUM_LED-1:0];
        end else if (io_wr_s && (addr[9:0] == OFF_SEG)) begin
            seg_r       <= wdata;
            seg_valid_r <= 1'b1;
        end else begin
            led_r <= led_r;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        mmio_btn_event #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk     (clk),
            .reset   (reset),
            .btn_raw (btn_in[i]),
            .clr     (btn_clr_s[i]),
            .evt     (btn_evt_s[i]),
            .lvl     (btn_lvl_s[i])
        );
    end

    assign rdata     = rdata_r;
    assign ready     = ready_r;
    assign led_out   = led_r;
    assign seg_value = seg_r;
    assign seg_valid = seg_valid_r;

endmodule
